noc_echo_node: RTL and testbench

Parametrised NoC test endpoint with credit-based flow control. It buffers received flits in a small FIFO and transforms each one with a fixed per-node signature, using either modular add or XOR. Each transformed flit goes back out on the send channel only when a downstream credit is available. It sits at a router local port and is used to fingerprint traffic paths during partitioning experiments.

---
 rtl/noc_echo_pkg.sv | 35 +++
 rtl/noc_echo_node_echo_fifo.sv | 76 +++++++
 rtl/noc_echo_node.sv | 148 ++++++++++++++
 tb/tb_noc_echo_node.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_echo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_echo_pkg
// Description : Shared constants and the flit transform used by the NoC
//               echo endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_echo_pkg;

  // Transform selectors for the MODE parameter
  localparam int MODE_ADD = 0;
  localparam int MODE_XOR = 1;

  // Widest flit the transform helper handles; callers zero-extend into this
  // width and truncate the result back to their own DATA_W. Modular add and
  // XOR both commute with truncation, so the low bits are exact.
  localparam int c_XFORM_MAX_W = 64;

  // Apply the per-node signature to one flit
  function automatic logic [c_XFORM_MAX_W-1:0] echo_transform(
    input logic [c_XFORM_MAX_W-1:0] data,
    input logic [c_XFORM_MAX_W-1:0] sig,
    input int                       mode
  );
    logic [c_XFORM_MAX_W-1:0] result;
    if (mode == MODE_XOR) begin
      result = data ^ sig;
    end else begin
      result = data + sig;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_echo_node_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : echo_fifo
// Description : Small receive FIFO for the NoC echo endpoint. Pointers carry
//               one extra wrap bit; the head is presented combinationally.
//               A write while full is dropped unless a pop frees the slot in
//               the same cycle. A pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Elaboration-time guard on the depth parameter
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("echo_fifo: DEPTH must be a power of 2 and at least 2");
  end

  // Occupancy flags from the wrap-bit pointer comparison
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_rd_ok = rd_en && !w_empty;
    w_wr_ok = wr_en && (!w_full || w_rd_ok);
  end

  // Pointer advance; reset discards any buffered flits
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset as the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign full    = w_full;
  assign empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/noc_echo_node.sv
`default_nettype none
// ============================================================================
// Module      : noc_echo_node
// Description : NoC test endpoint. Buffers received flits, applies a per-node
//               signature (add or XOR) and echoes each one on the send channel
//               whenever a downstream credit is held. Returns one receive
//               credit upstream per echoed flit.
//               Optional build macro NOC_ECHO_STATS_EN adds o_echo_count, a
//               wrapping 16-bit count of flits sent.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_echo_node
  import noc_echo_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] SIGNATURE = '0,
  parameter int                MODE      = MODE_ADD,
  parameter int                DEPTH     = 4,
  parameter int                CREDITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rvalid,
  output logic              o_rcredit,
  output logic [DATA_W-1:0] o_sdata,
  output logic              o_svalid,
  input  logic              i_scredit,
  output logic              o_overflow
`ifdef NOC_ECHO_STATS_EN
  ,
  output logic [15:0]       o_echo_count
`endif
);

  localparam int              CNT_W     = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CREDITS);

  // Elaboration-time guards on the configuration
  if (DATA_W < 2 || DATA_W > c_XFORM_MAX_W) begin : g_bad_width
    $error("noc_echo_node: DATA_W out of range");
  end
  if (CREDITS < 1 || CREDITS > 255) begin : g_bad_credits
    $error("noc_echo_node: CREDITS must be 1..255");
  end
  if (MODE != MODE_ADD && MODE != MODE_XOR) begin : g_bad_mode
    $error("noc_echo_node: MODE must be 0 (add) or 1 (xor)");
  end

  logic [DATA_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_send;
  logic [DATA_W-1:0] w_xform;
  logic [CNT_W-1:0]  w_cnt_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sdata;
  logic              r_svalid;
  logic              r_rcredit;
  logic              r_overflow;

  echo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (i_rvalid),
    .wr_data (i_rdata),
    .rd_en   (w_send),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Send decision and transformed head flit
  always_comb begin
    w_send  = !w_empty && (r_cnt != '0);
    w_xform = DATA_W'(echo_transform(c_XFORM_MAX_W'(w_head),
                                     c_XFORM_MAX_W'(SIGNATURE), MODE));
  end

  // Next credit count: +credit -send, saturating at the initial allowance
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_scredit && !w_send) begin
      if (r_cnt != c_CNT_MAX) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else if (!i_scredit && w_send) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  // Send credit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= c_CNT_MAX;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Registered send channel and receive-credit return
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sdata   <= '0;
      r_svalid  <= 1'b0;
      r_rcredit <= 1'b0;
    end else begin
      r_svalid  <= w_send;
      r_rcredit <= w_send;
      r_sdata   <= w_send ? w_xform : '0;
    end
  end

  // Sticky overflow: a flit arrived with no free slot and no pop to make one
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (i_rvalid && w_full && !w_send) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef NOC_ECHO_STATS_EN
  logic [15:0] r_echo_count;

  // Wrapping count of flits sent
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_echo_count <= '0;
    end else if (w_send) begin
      r_echo_count <= r_echo_count + 16'd1;
    end
  end

  assign o_echo_count = r_echo_count;
`endif

  assign o_sdata    = r_sdata;
  assign o_svalid   = r_svalid;
  assign o_rcredit  = r_rcredit;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_noc_echo_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_echo_node
// Description : Directed self-checking bench for noc_echo_node. Two instances:
//               dut_a (add, signature 0x0010) and dut_x (xor, signature
//               0x00FF), DATA_W=16, DEPTH=4, CREDITS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_echo_node;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [15:0] a_rdata = '0;
  logic        a_rvalid = 1'b0;
  logic        a_scredit = 1'b0;
  logic        a_rcredit;
  logic [15:0] a_sdata;
  logic        a_svalid;
  logic        a_overflow;
`ifdef NOC_ECHO_STATS_EN
  logic [15:0] a_echo_count;
  logic [15:0] x_echo_count;
`endif

  logic [15:0] x_rdata = '0;
  logic        x_rvalid = 1'b0;
  logic        x_scredit = 1'b0;
  logic        x_rcredit;
  logic [15:0] x_sdata;
  logic        x_svalid;
  logic        x_overflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got [$];

  always #5 clk = ~clk;

  noc_echo_node #(
    .DATA_W(16), .SIGNATURE(16'h0010), .MODE(0), .DEPTH(4), .CREDITS(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .i_rdata(a_rdata), .i_rvalid(a_rvalid), .o_rcredit(a_rcredit),
    .o_sdata(a_sdata), .o_svalid(a_svalid), .i_scredit(a_scredit),
    .o_overflow(a_overflow)
`ifdef NOC_ECHO_STATS_EN
    , .o_echo_count(a_echo_count)
`endif
  );

  noc_echo_node #(
    .DATA_W(16), .SIGNATURE(16'h00FF), .MODE(1), .DEPTH(4), .CREDITS(4)
  ) dut_x (
    .clk(clk), .rst(rst),
    .i_rdata(x_rdata), .i_rvalid(x_rvalid), .o_rcredit(x_rcredit),
    .o_sdata(x_sdata), .o_svalid(x_svalid), .i_scredit(x_scredit),
    .o_overflow(x_overflow)
`ifdef NOC_ECHO_STATS_EN
    , .o_echo_count(x_echo_count)
`endif
  );

  // Advance one rising edge, then settle so outputs are sampled off the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return n send credits to dut_a, one pulse per cycle
  task automatic return_credits(input int n);
    for (int i = 0; i < n; i++) begin
      a_scredit = 1'b1;
      step();
      a_scredit = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({a_svalid, a_rcredit, a_sdata, a_overflow} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got sv=%b rc=%b sd=%h ov=%b want all 0",
               a_svalid, a_rcredit, a_sdata, a_overflow);
    end
    checks++;
    if ({x_svalid, x_rcredit, x_sdata, x_overflow} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs_x got sv=%b rc=%b sd=%h ov=%b want all 0",
               x_svalid, x_rcredit, x_sdata, x_overflow);
    end
`ifdef NOC_ECHO_STATS_EN
    checks++;
    if (a_echo_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_echo_count got %h want 0000", a_echo_count);
    end
`endif
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({a_svalid, a_rcredit, a_sdata, a_overflow} !== 19'd0) begin
        failures++;
        $display("FAIL idle_cycle_%0d got sv=%b rc=%b sd=%h ov=%b want all 0",
                 i, a_svalid, a_rcredit, a_sdata, a_overflow);
      end
    end
  endtask

  task automatic test_add();
    logic [15:0] din [2];
    logic [15:0] dexp [2];
    din[0] = 16'h0005; dexp[0] = 16'h0015;
    din[1] = 16'hFFFF; dexp[1] = 16'h000F;
    for (int k = 0; k < 2; k++) begin
      a_rdata = din[k];
      a_rvalid = 1'b1;
      step();
      a_rvalid = 1'b0;
      checks++;
      if (a_svalid !== 1'b0) begin
        failures++;
        $display("FAIL add_early_%0d got svalid=%b want 0", k, a_svalid);
      end
      step();
      checks++;
      if ({a_svalid, a_rcredit, a_sdata} !== {1'b1, 1'b1, dexp[k]}) begin
        failures++;
        $display("FAIL add_echo_%0d got sv=%b rc=%b sd=%h want sv=1 rc=1 sd=%h",
                 k, a_svalid, a_rcredit, a_sdata, dexp[k]);
      end
      step();
      checks++;
      if ({a_svalid, a_rcredit, a_sdata} !== 18'd0) begin
        failures++;
        $display("FAIL add_after_%0d got sv=%b rc=%b sd=%h want all 0",
                 k, a_svalid, a_rcredit, a_sdata);
      end
    end
    return_credits(2);
  endtask

  task automatic test_xor();
    x_rdata = 16'h0F0F;
    x_rvalid = 1'b1;
    step();
    x_rvalid = 1'b0;
    checks++;
    if (x_svalid !== 1'b0) begin
      failures++;
      $display("FAIL xor_early got svalid=%b want 0", x_svalid);
    end
    step();
    checks++;
    if ({x_svalid, x_rcredit, x_sdata} !== {1'b1, 1'b1, 16'h0FF0}) begin
      failures++;
      $display("FAIL xor_echo got sv=%b rc=%b sd=%h want sv=1 rc=1 sd=0ff0",
               x_svalid, x_rcredit, x_sdata);
    end
  endtask

  task automatic test_credit_exhaust();
    got.delete();
    for (int c = 0; c < 12; c++) begin
      a_rvalid = (c < 6);
      a_rdata  = 16'h0100 + 16'(c);
      step();
      if (a_svalid === 1'b1) got.push_back(a_sdata);
    end
    a_rvalid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL exhaust_count got %0d sends want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (((i < got.size()) ? got[i] : 16'hxxxx) !== 16'h0110 + 16'(i)) begin
        failures++;
        $display("FAIL exhaust_data_%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, 16'h0110 + 16'(i));
      end
    end
    // Each credit releases exactly one buffered flit, in order
    for (int k = 0; k < 2; k++) begin
      a_scredit = 1'b1;
      step();
      a_scredit = 1'b0;
      checks++;
      if (a_svalid !== 1'b0) begin
        failures++;
        $display("FAIL release_early_%0d got svalid=%b want 0", k, a_svalid);
      end
      step();
      checks++;
      if ({a_svalid, a_sdata} !== {1'b1, 16'h0114 + 16'(k)}) begin
        failures++;
        $display("FAIL release_%0d got sv=%b sd=%h want sv=1 sd=%h",
                 k, a_svalid, a_sdata, 16'h0114 + 16'(k));
      end
    end
    checks++;
    if (a_overflow !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_no_overflow got %b want 0", a_overflow);
    end
  endtask

  // Entered with cnt = 0 and the FIFO empty
  task automatic test_overflow();
    for (int c = 0; c < 5; c++) begin
      a_rvalid = 1'b1;
      a_rdata  = 16'h0200 + 16'(c);
      step();
      if (c == 3) begin
        checks++;
        if (a_overflow !== 1'b0) begin
          failures++;
          $display("FAIL overflow_at_4th got %b want 0", a_overflow);
        end
      end
    end
    a_rvalid = 1'b0;
    checks++;
    if (a_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_at_5th got %b want 1", a_overflow);
    end
    step();
    step();
    got.delete();
    for (int c = 0; c < 10; c++) begin
      a_scredit = (c < 4);
      step();
      if (a_svalid === 1'b1) got.push_back(a_sdata);
    end
    a_scredit = 1'b0;
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL overflow_echo_count got %0d sends want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (((i < got.size()) ? got[i] : 16'hxxxx) !== 16'h0210 + 16'(i)) begin
        failures++;
        $display("FAIL overflow_data_%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, 16'h0210 + 16'(i));
      end
    end
    checks++;
    if (a_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky got %b want 1", a_overflow);
    end
  endtask

  task automatic test_saturation_and_reset();
    int n;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (a_overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_cleared got %b want 0", a_overflow);
    end
    return_credits(3);  // cnt already at maximum: all ignored
    got.delete();
    for (int c = 0; c < 12; c++) begin
      a_rvalid = (c < 7);
      a_rdata  = 16'h0300 + 16'(c);
      step();
      if (a_svalid === 1'b1) got.push_back(a_sdata);
    end
    a_rvalid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL saturate_count got %0d sends want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (((i < got.size()) ? got[i] : 16'hxxxx) !== 16'h0310 + 16'(i)) begin
        failures++;
        $display("FAIL saturate_data_%0d got %h want %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, 16'h0310 + 16'(i));
      end
    end
`ifdef NOC_ECHO_STATS_EN
    checks++;
    if (a_echo_count !== 16'd4) begin
      failures++;
      $display("FAIL echo_count_before_reset got %h want 0004", a_echo_count);
    end
`endif
    // Three flits are buffered now; reset must discard them
    rst = 1'b0;
    step();
    rst = 1'b1;
`ifdef NOC_ECHO_STATS_EN
    checks++;
    if (a_echo_count !== 16'd0) begin
      failures++;
      $display("FAIL echo_count_after_reset got %h want 0000", a_echo_count);
    end
`endif
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (a_svalid !== 1'b0 || a_rcredit !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL mid_reset_discard got %0d pulse cycles want 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_xor();
    test_credit_exhaust();
    test_overflow();
    test_saturation_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
